// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: 24-hour time-of-day counter clocked at 1 Hz.
// The two buttons are edge-detected. Mode walks RUN -> SET_HOUR -> SET_MIN -> RUN.
// Increment edits the field being set. An idle timeout drops a set state back to RUN.
// The state is visible on the mode output.
// Optional alarm comparator is built only when CLOCK_ALARM_EN is defined;
// the default build ties alarm_hit low and leaves alarm_hour/alarm_min unused.
module clock_time_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic       sec_clk,
    input  logic       rstn,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic [5:0] sec_cnt,
    output logic [5:0] min_cnt,
    output logic [4:0] hour_cnt,
    output logic       min_tick,
    output logic       hour_tick,
    output logic [1:0] mode,
    output logic       blink,
    output logic       alarm_hit
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        ILLEGAL  = 2'b11
    } state_t;

    // Last quiet cycle value of the idle counter; the next quiet cycle times out.
    localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       mode_prev, inc_prev;
    logic [5:0] idle_q, idle_d;
    logic [5:0] sec_d, min_d;
    logic [4:0] hour_d;
    logic       min_tick_d, hour_tick_d, blink_d, alarm_d;
    logic       mode_edge, inc_press, inc_edge, any_edge, timeout_hit;
    logic       set_d;

    // Mode edge wins over a simultaneous inc edge, which is then dropped.
    assign mode_edge   = mode_btn & ~mode_prev;
    assign inc_press   = inc_btn & ~inc_prev;
    assign inc_edge    = inc_press & ~mode_edge;
    assign any_edge    = mode_edge | inc_press;
    assign timeout_hit = (idle_q == IDLE_LAST) && !any_edge;
    assign set_d       = (state_d == SET_HOUR) || (state_d == SET_MIN);

    // State register, button history and idle counter.
    always_ff @(posedge sec_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= RUN;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
            idle_q    <= 6'd0;
        end else begin
            state_q   <= state_d;
            mode_prev <= mode_btn;
            inc_prev  <= inc_btn;
            idle_q    <= idle_d;
        end
    end

    // Next-state logic: mode edges step through the set states, timeout returns to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mode_edge) state_d = SET_HOUR;
            SET_HOUR: begin
                if (mode_edge)        state_d = SET_MIN;
                else if (timeout_hit) state_d = RUN;
            end
            SET_MIN:  if (mode_edge || timeout_hit) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Datapath next values: counting in RUN, field edits in set states, seconds
    // cleared on any exit from a set state.
    always_comb begin
        sec_d       = sec_cnt;
        min_d       = min_cnt;
        hour_d      = hour_cnt;
        min_tick_d  = 1'b0;
        hour_tick_d = 1'b0;
        alarm_d     = 1'b0;
        case (state_q)
            RUN: begin
                // The cycle that takes the mode edge is frozen, not counted.
                if (!mode_edge) begin
                    if (sec_cnt == 6'd59) begin
                        sec_d      = 6'd0;
                        min_tick_d = 1'b1;
                        if (min_cnt == 6'd59) begin
                            min_d       = 6'd0;
                            hour_tick_d = 1'b1;
                            hour_d      = (hour_cnt == 5'd23) ? 5'd0 : hour_cnt + 5'd1;
                        end else begin
                            min_d = min_cnt + 6'd1;
                        end
                    end else begin
                        sec_d = sec_cnt + 6'd1;
                    end
                end
            end
            SET_HOUR: begin
                if (inc_edge) begin
                    hour_d      = (hour_cnt == 5'd23) ? 5'd0 : hour_cnt + 5'd1;
                    hour_tick_d = 1'b1;
                end
                if (state_d == RUN) sec_d = 6'd0;
            end
            SET_MIN: begin
                if (inc_edge) begin
                    min_d      = (min_cnt == 6'd59) ? 6'd0 : min_cnt + 6'd1;
                    min_tick_d = 1'b1;
                end
                if (state_d == RUN) sec_d = 6'd0;
            end
            default: ;
        endcase

`ifdef CLOCK_ALARM_EN
        // Alarm fires only when RUN counting lands on hh:mm:00, never from edits or exits.
        if (state_q == RUN && !mode_edge && sec_d == 6'd0 &&
            hour_d == alarm_hour && min_d == alarm_min)
            alarm_d = 1'b1;
`endif

        // Blink starts at 1 on entering a set state and toggles while staying.
        if (!set_d)                blink_d = 1'b0;
        else if (state_d != state_q) blink_d = 1'b1;
        else                       blink_d = ~blink;

        // Idle counter runs only across quiet cycles inside one set state.
        if (set_d && state_d == state_q && !any_edge) idle_d = idle_q + 6'd1;
        else                                          idle_d = 6'd0;
    end

`ifndef CLOCK_ALARM_EN
    // Alarm inputs have no function in this build.
    logic alarm_unused;
    assign alarm_unused = ^{alarm_hour, alarm_min};
`endif

    // Registered counters and one-cycle pulses.
    always_ff @(posedge sec_clk or negedge rstn) begin
        if (!rstn) begin
            sec_cnt   <= 6'd0;
            min_cnt   <= 6'd0;
            hour_cnt  <= 5'd0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            blink     <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            sec_cnt   <= sec_d;
            min_cnt   <= min_d;
            hour_cnt  <= hour_d;
            min_tick  <= min_tick_d;
            hour_tick <= hour_tick_d;
            blink     <= blink_d;
            alarm_hit <= alarm_d;
        end
    end

    // Output decode: the mode port is the raw state encoding.
    always_comb begin
        mode = state_q;
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: fixed vector table for the set sequence, hand
// sequences for rollover, priority, timeout, alarm and reset, then random
// button traffic checked against a seconds-of-day reference model.
module tb_clock_time_ctrl;

    localparam int TIMEOUT = 30;
    localparam int W = 23;

    logic       sec_clk;
    logic       rstn;
    logic       mode_btn, inc_btn;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [5:0] sec_cnt, min_cnt;
    logic [4:0] hour_cnt;
    logic       min_tick, hour_tick, blink, alarm_hit;
    logic [1:0] mode;

    int n_cmp = 0;
    int n_bad = 0;

    clock_time_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .sec_clk(sec_clk), .rstn(rstn), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .sec_cnt(sec_cnt), .min_cnt(min_cnt), .hour_cnt(hour_cnt),
        .min_tick(min_tick), .hour_tick(hour_tick), .mode(mode),
        .blink(blink), .alarm_hit(alarm_hit)
    );

    // ---------------- clock ----------------
    initial begin
        sec_clk = 1'b0;
        forever #5 sec_clk = ~sec_clk;
    end

    // ---------------- reference model ----------------
    // Time is kept as seconds since midnight; the mode is 0 run, 1 hour, 2 minute.
    int m_tod, m_state, m_quiet, m_set_cycles;
    bit m_pm, m_pi;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] pack_exp(int st, int tod, bit mt, bit ht, bit bl, bit al);
        logic [1:0] f_mode;
        logic [4:0] f_h;
        logic [5:0] f_m, f_s;
        f_mode = 2'(st);
        f_h    = 5'(tod / 3600);
        f_m    = 6'((tod / 60) % 60);
        f_s    = 6'(tod % 60);
        return {f_mode, f_h, f_m, f_s, mt, ht, bl, al};
    endfunction

    task automatic model_reset();
        m_tod = 0; m_state = 0; m_quiet = 0; m_set_cycles = 0;
        m_pm = 0; m_pi = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit mb, input bit ib);
        bit me, ie, any_press, mt, ht, al;
        int h, m, s;
        me = mb && !m_pm;
        any_press = me || (ib && !m_pi);
        ie = ib && !m_pi && !me;
        m_pm = mb; m_pi = ib;
        mt = 0; ht = 0; al = 0;
        h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
        if (m_state == 0) begin
            if (me) begin
                m_state = 1; m_quiet = 0; m_set_cycles = 0;
            end else begin
                m_tod = (m_tod + 1) % 86400;
                mt = (m_tod % 60) == 0;
                ht = (m_tod % 3600) == 0;
`ifdef CLOCK_ALARM_EN
                al = (m_tod == int'(alarm_hour) * 3600 + int'(alarm_min) * 60);
`endif
            end
        end else if (me) begin
            if (m_state == 1) begin
                m_state = 2; m_quiet = 0; m_set_cycles = 0;
            end else begin
                m_state = 0; m_tod = (m_tod / 60) * 60;
            end
        end else begin
            if (ie) begin
                if (m_state == 1) begin h = (h + 1) % 24; ht = 1; end
                else              begin m = (m + 1) % 60; mt = 1; end
                m_tod = h * 3600 + m * 60 + s;
            end
            m_set_cycles++;
            if (any_press) m_quiet = 0;
            else           m_quiet++;
            if (m_quiet == TIMEOUT) begin
                m_state = 0; m_tod = (m_tod / 60) * 60;
            end
        end
        exp_q.push_back(pack_exp(m_state, m_tod, mt, ht,
                                 (m_state != 0) && (m_set_cycles % 2 == 0), al));
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_model();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("sb_mode",  int'(mode),      int'(e[22:21]));
            chk("sb_hour",  int'(hour_cnt),  int'(e[20:16]));
            chk("sb_min",   int'(min_cnt),   int'(e[15:10]));
            chk("sb_sec",   int'(sec_cnt),   int'(e[9:4]));
            chk("sb_mtick", int'(min_tick),  int'(e[3]));
            chk("sb_htick", int'(hour_tick), int'(e[2]));
            chk("sb_blink", int'(blink),     int'(e[1]));
            chk("sb_alarm", int'(alarm_hit), int'(e[0]));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick(input bit mb, input bit ib);
        mode_btn = mb;
        inc_btn  = ib;
        @(posedge sec_clk);
        model_step(mb, ib);
        #1;
        check_model();
    endtask

    task automatic press(input bit is_mode);
        tick(is_mode, !is_mode);
        tick(1'b0, 1'b0);
    endtask

    // From RUN: walk both set states to reach hh:mm, then confirm.
    task automatic set_time(input int h, input int m);
        int cur_h, cur_m;
        press(1'b1);
        cur_h = m_tod / 3600;
        repeat ((h - cur_h + 24) % 24) press(1'b0);
        press(1'b1);
        cur_m = (m_tod / 60) % 60;
        repeat ((m - cur_m + 60) % 60) press(1'b0);
        press(1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sec"},   int'(sec_cnt),   0);
        chk({tag, "_min"},   int'(min_cnt),   0);
        chk({tag, "_hour"},  int'(hour_cnt),  0);
        chk({tag, "_mode"},  int'(mode),      0);
        chk({tag, "_ticks"}, int'({min_tick, hour_tick}), 0);
        chk({tag, "_blink"}, int'(blink),     0);
        chk({tag, "_alarm"}, int'(alarm_hit), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit mb; bit ib;
        int mode; int hour; int min; int sec;
        bit ht; bit mt; bit bl;
    } vec_t;
    vec_t vecs[20];

    // ---------------- main sequence ----------------
    initial begin
        int saved_h;
        // Set sequence 10:20:01 -> +3 hours, +5 minutes -> confirm -> 13:25:00.
        vecs[0]  = '{1, 0, 1, 10, 20, 1, 0, 0, 1};
        vecs[1]  = '{0, 1, 1, 11, 20, 1, 1, 0, 0};
        vecs[2]  = '{0, 0, 1, 11, 20, 1, 0, 0, 1};
        vecs[3]  = '{0, 1, 1, 12, 20, 1, 1, 0, 0};
        vecs[4]  = '{0, 0, 1, 12, 20, 1, 0, 0, 1};
        vecs[5]  = '{0, 1, 1, 13, 20, 1, 1, 0, 0};
        vecs[6]  = '{0, 0, 1, 13, 20, 1, 0, 0, 1};
        vecs[7]  = '{1, 0, 2, 13, 20, 1, 0, 0, 1};
        vecs[8]  = '{0, 1, 2, 13, 21, 1, 0, 1, 0};
        vecs[9]  = '{0, 0, 2, 13, 21, 1, 0, 0, 1};
        vecs[10] = '{0, 1, 2, 13, 22, 1, 0, 1, 0};
        vecs[11] = '{0, 0, 2, 13, 22, 1, 0, 0, 1};
        vecs[12] = '{0, 1, 2, 13, 23, 1, 0, 1, 0};
        vecs[13] = '{0, 0, 2, 13, 23, 1, 0, 0, 1};
        vecs[14] = '{0, 1, 2, 13, 24, 1, 0, 1, 0};
        vecs[15] = '{0, 0, 2, 13, 24, 1, 0, 0, 1};
        vecs[16] = '{0, 1, 2, 13, 25, 1, 0, 1, 0};
        vecs[17] = '{0, 0, 2, 13, 25, 1, 0, 0, 1};
        vecs[18] = '{1, 0, 0, 13, 25, 0, 0, 0, 0};
        vecs[19] = '{0, 0, 0, 13, 25, 1, 0, 0, 0};

        // Reset block.
        rstn = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
        alarm_hour = 5'd0; alarm_min = 6'd0;
        model_reset();
        repeat (3) @(posedge sec_clk);
        #1;
        chk_reset_outputs("rst");
        rstn = 1'b1;
        tick(1'b0, 1'b0);
        chk("first_sec", int'(sec_cnt), 1);

        // Table-driven set sequence.
        set_time(10, 20);
        chk("preset_time", int'(hour_cnt) * 100 + int'(min_cnt), 1020);
        for (int i = 0; i < 20; i++) begin
            tick(vecs[i].mb, vecs[i].ib);
            chk($sformatf("vec%0d_mode", i),  int'(mode),      vecs[i].mode);
            chk($sformatf("vec%0d_hour", i),  int'(hour_cnt),  vecs[i].hour);
            chk($sformatf("vec%0d_min", i),   int'(min_cnt),   vecs[i].min);
            chk($sformatf("vec%0d_sec", i),   int'(sec_cnt),   vecs[i].sec);
            chk($sformatf("vec%0d_htick", i), int'(hour_tick), int'(vecs[i].ht));
            chk($sformatf("vec%0d_mtick", i), int'(min_tick),  int'(vecs[i].mt));
            chk($sformatf("vec%0d_blink", i), int'(blink),     int'(vecs[i].bl));
        end

        // Priority: mode and inc rise together in SET_HOUR.
        press(1'b1);
        saved_h = int'(hour_cnt);
        tick(1'b1, 1'b1);
        chk("prio_mode", int'(mode), 2);
        chk("prio_hour", int'(hour_cnt), saved_h);
        chk("prio_htick", int'(hour_tick), 0);
        tick(1'b0, 1'b0);
        press(1'b1);

        // Rollover 23:59:58 -> 00:00:00.
        set_time(23, 59);
        repeat (57) tick(1'b0, 1'b0);
        chk("roll_pre_sec", int'(sec_cnt), 58);
        tick(1'b0, 1'b0);
        chk("roll_59_ticks", int'({min_tick, hour_tick}), 0);
        tick(1'b0, 1'b0);
        chk("roll_time", int'(hour_cnt) * 10000 + int'(min_cnt) * 100 + int'(sec_cnt), 0);
        chk("roll_mtick", int'(min_tick), 1);
        chk("roll_htick", int'(hour_tick), 1);
        tick(1'b0, 1'b0);
        chk("roll_after_ticks", int'({min_tick, hour_tick}), 0);

        // Timeout: 30 quiet cycles in SET_HOUR.
        tick(1'b1, 1'b0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick(1'b0, 1'b0);
            if (i == TIMEOUT - 1) chk("tmo_still_set", int'(mode), 1);
        end
        chk("tmo_mode", int'(mode), 0);
        chk("tmo_sec", int'(sec_cnt), 0);
        chk("tmo_blink", int'(blink), 0);

`ifdef CLOCK_ALARM_EN
        // Alarm at 07:30 reached by counting, then by editing (no pulse).
        alarm_hour = 5'd7; alarm_min = 6'd30;
        set_time(7, 29);
        repeat (57) tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("alm_early", int'(alarm_hit), 0);
        tick(1'b0, 1'b0);
        chk("alm_hit", int'(alarm_hit), 1);
        chk("alm_time", int'(hour_cnt) * 100 + int'(min_cnt), 730);
        tick(1'b0, 1'b0);
        chk("alm_one_cycle", int'(alarm_hit), 0);
        set_time(7, 29);
        press(1'b1);
        press(1'b1);
        tick(1'b0, 1'b1);
        chk("alm_edit", int'(alarm_hit), 0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk("alm_confirm", int'(alarm_hit), 0);
        chk("alm_confirm_time", int'(hour_cnt) * 100 + int'(min_cnt), 730);
        tick(1'b0, 1'b0);
`endif

        // Reset during SET_MIN with inc held.
        press(1'b1);
        press(1'b1);
        tick(1'b0, 1'b1);
        chk("rmid_in_setmin", int'(mode), 2);
        rstn = 1'b0;
        #1;
        chk_reset_outputs("rmid_async");
        repeat (2) @(posedge sec_clk);
        #1;
        chk_reset_outputs("rmid_held");
        rstn = 1'b1;
        model_reset();
        tick(1'b0, 1'b1);
        chk("rmid_sec", int'(sec_cnt), 1);
        chk("rmid_mode", int'(mode), 0);
        chk("rmid_ticks", int'({min_tick, hour_tick}), 0);

        // Random button traffic against the model.
        alarm_hour = 5'($urandom_range(0, 23));
        alarm_min  = 6'($urandom_range(0, 59));
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) begin
                alarm_hour = 5'(m_tod / 3600);
                alarm_min  = 6'(((m_tod / 60) + 1) % 60);
            end
            tick(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
